full_adder_checker: RTL and testbench

- Synthesizable response checker: the receiving end of the full-adder stimulus sequence.
- Samples the adder's applied inputs {a, b, cin} and observed outputs {s, cout} under a valid strobe.
- Compares the observed outputs against a golden model and counts passes and failures.
- Tracks which of the 8 one-bit input combinations have been seen; raises done once all are covered, and flags a stalled stimulus source.

---
 rtl/fa_check_pkg.sv | 24 ++
 rtl/fa_sat_counter.sv | 33 +++
 rtl/full_adder_checker.sv | 198 +++++++++++++++++++
 tb/tb_full_adder_checker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fa_check_pkg.sv
// Shared definitions for the full-adder response checker.
//   state_t      : session state encoding (IDLE, CHECK, DONE, TOUT)
//   COV_ALL      : coverage mask value once all 8 one-bit combinations are seen
//   fa_expected  : golden model, a + b + cin as an unsigned sum with carry
package fa_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2,
        TOUT  = 2'd3
    } state_t;

    localparam logic [7:0] COV_ALL = 8'hFF;

    // Operands are zero-extended to the widest supported WIDTH (8); callers
    // truncate the 9-bit result to their own WIDTH+1.
    function automatic logic [8:0] fa_expected(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic       cin);
        return {1'b0, a} + {1'b0, b} + {8'd0, cin};
    endfunction

endpackage

// File: rtl/fa_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to zero (wins over inc)
//   inc        : add one unless already at MAX
//   cnt        : current count
module fa_sat_counter #(
    parameter int          W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != MAX_V)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/full_adder_checker.sv
// Response checker for a WIDTH-bit full adder.
// Samples {a, b, cin} and the observed {cout, s} under in_valid, compares
// against the golden sum two stages later, and keeps pass/fail counts, a
// one-bit input coverage mask and the first failing input vector.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : clear results and (re)enter CHECK
//   in_valid, in_a, in_b, in_cin, in_s, in_cout : sample under test
//   busy              : session in progress (CHECK)
//   pass_cnt/fail_cnt : saturating match / mismatch counts
//   cov_mask          : bit {a[0],b[0],cin} set once that combination is seen
//   first_fail_valid/first_fail_vec : {a,b,cin} of the first mismatch
//   done              : full coverage reached, nothing left to score
//   timeout           : no sample for TIMEOUT cycles during CHECK
module full_adder_checker
    import fa_check_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   in_s,
    input  logic               in_cout,
    output logic               busy,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [7:0]         cov_mask,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_vec,
    output logic               done,
    output logic               timeout
);

    localparam int unsigned          CNT_MAX  = (1 << CNT_W) - 1;
    localparam int                   IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam int                   VEC_W    = 2 * WIDTH + 1;

    state_t state_reg, state_next;

    logic             take;
    logic             s1_valid_reg;
    logic [VEC_W-1:0] s1_vec_reg;
    logic [WIDTH:0]   s1_obs_reg;
    logic [WIDTH:0]   s1_exp_reg;
    logic             s2_valid_reg;
    logic             s2_match_reg;
    logic [VEC_W-1:0] s2_vec_reg;
    logic [2:0]       s2_cov_idx;
    logic [7:0]       cov_mask_reg;
    logic             ff_valid_reg;
    logic [VEC_W-1:0] ff_vec_reg;
    logic [IDLE_W-1:0] idle_cnt;
    logic             idle_sat;

    // A sample is accepted only in CHECK; start in the same cycle discards it.
    assign take = in_valid && (state_reg == CHECK) && !start;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // Coverage is tested before the idle limit so DONE wins a tie.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = CHECK;
        end else begin
            case (state_reg)
                CHECK: begin
                    if ((cov_mask_reg == COV_ALL) && !s2_valid_reg) begin
                        state_next = DONE;
                    end else if (idle_sat) begin
                        state_next = TOUT;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // ---------------- state outputs ----------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_reg)
            CHECK:   busy    = 1'b1;
            DONE:    done    = 1'b1;
            TOUT:    timeout = 1'b1;
            default: ;
        endcase
    end

    // ---------------- stage 1: capture and golden sum ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_vec_reg   <= '0;
            s1_obs_reg   <= '0;
            s1_exp_reg   <= '0;
        end else if (start) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= take;
            if (take) begin
                s1_vec_reg <= {in_a, in_b, in_cin};
                s1_obs_reg <= {in_cout, in_s};
                s1_exp_reg <= (WIDTH + 1)'(fa_expected(8'(in_a), 8'(in_b), in_cin));
            end
        end
    end

    // ---------------- stage 2: compare ----------------
    // Stage 1/2 keep advancing outside CHECK so an in-flight sample still scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_match_reg <= 1'b0;
            s2_vec_reg   <= '0;
        end else if (start) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_match_reg <= (s1_obs_reg == s1_exp_reg);
                s2_vec_reg   <= s1_vec_reg;
            end
        end
    end

    // Coverage index is {a[0], b[0], cin} out of the packed {a, b, cin} vector.
    assign s2_cov_idx = {s2_vec_reg[WIDTH+1], s2_vec_reg[1], s2_vec_reg[0]};

    // ---------------- coverage and first-fail capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cov_mask_reg <= '0;
            ff_valid_reg <= 1'b0;
            ff_vec_reg   <= '0;
        end else if (start) begin
            cov_mask_reg <= '0;
            ff_valid_reg <= 1'b0;
            ff_vec_reg   <= '0;
        end else if (s2_valid_reg) begin
            cov_mask_reg <= cov_mask_reg | (8'd1 << s2_cov_idx);
            if (!s2_match_reg && !ff_valid_reg) begin
                ff_valid_reg <= 1'b1;
                ff_vec_reg   <= s2_vec_reg;
            end
        end
    end

    // ---------------- counters ----------------
    fa_sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (s2_valid_reg && s2_match_reg),
        .cnt   (pass_cnt)
    );

    fa_sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (s2_valid_reg && !s2_match_reg),
        .cnt   (fail_cnt)
    );

    // Idle counter restarts on any strobe and only runs while in CHECK.
    fa_sat_counter #(.W(IDLE_W), .MAX(TIMEOUT)) u_idle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start || in_valid),
        .inc   ((state_reg == CHECK) && !in_valid),
        .cnt   (idle_cnt)
    );

    assign idle_sat = (idle_cnt == IDLE_MAX);

    assign cov_mask         = cov_mask_reg;
    assign first_fail_valid = ff_valid_reg;
    assign first_fail_vec   = ff_vec_reg;

endmodule

// File: tb/tb_full_adder_checker.sv
module tb_full_adder_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [0:0] in_a, in_b, in_s;
    logic       in_cin, in_cout;

    // main instance (CNT_W = 8)
    logic       busy, ff_valid, done, timeout;
    logic [7:0] pass_cnt, fail_cnt, cov_mask;
    logic [2:0] ff_vec;

    // narrow-counter instance (CNT_W = 2) sharing the same stimulus
    logic       busy2, ff_valid2, done2, timeout2;
    logic [1:0] pass_cnt2, fail_cnt2;
    logic [7:0] cov_mask2;
    logic [2:0] ff_vec2;

    int checks   = 0;
    int failures = 0;

    // Hand-computed full-adder truth table, indexed by {a, b, cin}.
    logic [7:0] s_tab    = 8'b1001_0110;
    logic [7:0] cout_tab = 8'b1110_1000;

    always #5 clk = ~clk;

    full_adder_checker #(.WIDTH(1), .CNT_W(8), .TIMEOUT(64)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_a (in_a), .in_b (in_b), .in_cin (in_cin), .in_s (in_s), .in_cout (in_cout),
        .busy (busy), .pass_cnt (pass_cnt), .fail_cnt (fail_cnt), .cov_mask (cov_mask),
        .first_fail_valid (ff_valid), .first_fail_vec (ff_vec),
        .done (done), .timeout (timeout)
    );

    full_adder_checker #(.WIDTH(1), .CNT_W(2), .TIMEOUT(64)) dut2 (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_a (in_a), .in_b (in_b), .in_cin (in_cin), .in_s (in_s), .in_cout (in_cout),
        .busy (busy2), .pass_cnt (pass_cnt2), .fail_cnt (fail_cnt2), .cov_mask (cov_mask2),
        .first_fail_valid (ff_valid2), .first_fail_vec (ff_vec2),
        .done (done2), .timeout (timeout2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        $display("start");
    endtask

    // One sample of combination i; flip corrupts the observed sum bit.
    task automatic send(input int i, input logic flip);
        logic [2:0] v;
        v = i[2:0];
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v[2];
        in_b     = v[1];
        in_cin   = v[0];
        in_s     = s_tab[i] ^ flip;
        in_cout  = cout_tab[i];
        $display("sample a=%0d b=%0d cin=%0d s=%0d cout=%0d", in_a, in_b, in_cin, in_s, in_cout);
    endtask

    task automatic end_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_s = '0; in_cout = 1'b0;
        wait_n(3);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_cov", cov_mask, 0);
        chk("rst_done", done, 0);
        chk("rst_tout", timeout, 0);
        rst_n = 1'b1;
        wait_n(2);
        chk("idle_busy", busy, 0);

        // 1: all eight combinations, all correct
        do_start();
        chk("t1_busy_start", busy, 1);
        for (int i = 0; i < 8; i++) send(i, 1'b0);
        end_valid();
        wait_n(2);
        chk("t1_pass", pass_cnt, 8);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_cov", cov_mask, 8'hFF);
        chk("t1_done_early", done, 0);
        wait_n(1);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ffv", ff_valid, 0);

        // 2: corrupt the sum of combination 5 (a=1,b=0,cin=1)
        do_start();
        chk("t2_clear_pass", pass_cnt, 0);
        for (int i = 0; i < 8; i++) send(i, (i == 5));
        end_valid();
        wait_n(3);
        chk("t2_pass", pass_cnt, 7);
        chk("t2_fail", fail_cnt, 1);
        chk("t2_ffv", ff_valid, 1);
        chk("t2_ffvec", ff_vec, 3'b101);
        chk("t2_done", done, 1);

        // 3: three samples then a stall
        do_start();
        for (int i = 0; i < 3; i++) send(i, 1'b0);
        end_valid();
        wait_n(64);
        chk("t3_tout_early", timeout, 0);
        wait_n(1);
        chk("t3_tout", timeout, 1);
        chk("t3_busy", busy, 0);
        chk("t3_pass", pass_cnt, 3);
        chk("t3_done", done, 0);

        // 4: sample coincident with start is discarded
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1;
        in_a = 1'b1; in_b = 1'b1; in_cin = 1'b1; in_s = 1'b1; in_cout = 1'b1;
        $display("start with sample a=1 b=1 cin=1");
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        wait_n(2);
        chk("t4_pass", pass_cnt, 0);
        chk("t4_cov", cov_mask, 0);
        chk("t4_busy", busy, 1);

        // 5: saturation of a 2-bit counter
        do_start();
        for (int i = 0; i < 6; i++) send(0, 1'b0);
        end_valid();
        wait_n(3);
        chk("t5_pass2_sat", pass_cnt2, 3);
        chk("t5_pass_wide", pass_cnt, 6);
        chk("t5_cov2", cov_mask2, 8'h01);
        chk("t5_done2", done2, 0);

        // 6: reset in the middle of a session with samples in flight
        do_start();
        for (int i = 0; i < 4; i++) send(i, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        $display("reset asserted");
        #1;
        chk("t6_pass", pass_cnt, 0);
        chk("t6_cov", cov_mask, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ffv", ff_valid, 0);
        wait_n(1);
        rst_n = 1'b1;
        wait_n(3);
        chk("t6_busy_after", busy, 0);
        chk("t6_pass_after", pass_cnt, 0);
        chk("t6_cov_after", cov_mask, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
